// File: rtl/aux_pkg.sv
// Shared definitions for aux-bus targets.
//   - register word indices for the timer target
//   - CTRL bit positions
//   - aux request struct and tag width
//   - byte-strobe merge helper
package aux_pkg;

    localparam int AUX_TAG_W = 9;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_RELOAD  = 3'd1;
    localparam logic [2:0] REG_COUNT   = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_SCRATCH = 3'd4;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQEN      = 2;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;   // on reads, [AUX_TAG_W-1:0] is the tag
    } aux_req_t;

    // Replace the bytes of old_val selected by strb with those of new_val.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_val[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/aux_target_pipe.sv
// Generic aux-bus target front end.
//   - S1 captures a hit request at the edge ending cycle N.
//   - In cycle N+1 the abort input qualifies the S1 entry: a surviving
//     write is presented on wr_* for the parent to commit at that edge, a
//     surviving read registers rd_data (supplied by the parent's mux, indexed
//     by s1_idx) into the response register, driven during N+2.
// Ports:
//   clock, reset         : clock, async active-high reset
//   request, req, abort  : aux request in and abort of previous-cycle request
//   wr_en/wr_strb/wr_data: write commit strobe and payload (index = s1_idx)
//   s1_idx               : register index of the S1 entry (read mux select)
//   rd_data              : parent's read mux output for s1_idx
//   rvalid/rdata/rtag    : registered response, zero when not valid
module aux_target_pipe
    import aux_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hE000_0100
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 request,
    input  aux_req_t             req,
    input  logic                 abort,
    output logic                 wr_en,
    output logic [2:0]           s1_idx,
    output logic [3:0]           wr_strb,
    output logic [31:0]          wr_data,
    input  logic [31:0]          rd_data,
    output logic                 rvalid,
    output logic [31:0]          rdata,
    output logic [AUX_TAG_W-1:0] rtag
);

    logic                 s1_vld_q,   s1_vld_d;
    logic                 s1_write_q, s1_write_d;
    logic [2:0]           s1_idx_q,   s1_idx_d;
    logic [3:0]           s1_strb_q,  s1_strb_d;
    logic [31:0]          s1_wdata_q, s1_wdata_d;
    logic                 rvalid_q,   rvalid_d;
    logic [31:0]          rdata_q,    rdata_d;
    logic [AUX_TAG_W-1:0] rtag_q,     rtag_d;
    logic                 live;
    logic                 rd_fire;
    logic                 unused_addr_bits;

    // Byte offset within the word carries no meaning on this bus.
    assign unused_addr_bits = ^req.addr[1:0];

    always_comb begin
        s1_vld_d   = request && (req.addr[31:5] == BASE_ADDR[31:5]);
        s1_write_d = req.write;
        s1_idx_d   = req.addr[4:2];
        s1_strb_d  = req.wstrb;
        s1_wdata_d = req.wdata;

        live     = s1_vld_q && !abort;
        rd_fire  = live && !s1_write_q;
        rvalid_d = rd_fire;
        rdata_d  = rd_fire ? rd_data : '0;
        rtag_d   = rd_fire ? s1_wdata_q[AUX_TAG_W-1:0] : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_vld_q   <= 1'b0;
            s1_write_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_strb_q  <= '0;
            s1_wdata_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rtag_q     <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_write_q <= s1_write_d;
            s1_idx_q   <= s1_idx_d;
            s1_strb_q  <= s1_strb_d;
            s1_wdata_q <= s1_wdata_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rtag_q     <= rtag_d;
        end
    end

    assign wr_en   = live && s1_write_q;
    assign s1_idx  = s1_idx_q;
    assign wr_strb = s1_strb_q;
    assign wr_data = s1_wdata_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rtag    = rtag_q;

endmodule

// File: rtl/aux_timer_target.sv
// Aux-bus timer target: down-counting timer with auto-reload, sticky
// EXPIRED flag, level interrupt and a scratch register.
// Ports:
//   clock, reset                 : clock, async active-high reset
//   cpu_aux_request/addr/write   : request valid, byte address, direction
//   cpu_aux_wstrb/wdata          : byte enables, write data (tag on reads)
//   cpu_aux_abort                : cancels the previous-cycle request
//   timer_aux_rvalid/rdata/rtag  : read response, zero when not valid
//   timer_irq                    : EXPIRED && IRQEN, registered
module aux_timer_target
    import aux_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hE000_0100,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cpu_aux_request,
    input  logic [31:0]          cpu_aux_addr,
    input  logic                 cpu_aux_write,
    input  logic [3:0]           cpu_aux_wstrb,
    input  logic [31:0]          cpu_aux_wdata,
    input  logic                 cpu_aux_abort,
    output logic                 timer_aux_rvalid,
    output logic [31:0]          timer_aux_rdata,
    output logic [AUX_TAG_W-1:0] timer_aux_rtag,
    output logic                 timer_irq
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    aux_req_t    req;
    logic        wr_en;
    logic [2:0]  s1_idx;
    logic [3:0]  wr_strb;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    logic [2:0]  ctrl_q,    ctrl_d;
    logic [31:0] reload_q,  reload_d;
    logic [31:0] count_q,   count_d;
    logic        expired_q, expired_d;
    logic [31:0] scratch_q, scratch_d;
    logic [15:0] presc_q,   presc_d;
    logic        irq_q,     irq_d;
    logic        tick;
    logic        expire;

    assign req = '{write: cpu_aux_write, addr: cpu_aux_addr,
                   wstrb: cpu_aux_wstrb, wdata: cpu_aux_wdata};

    aux_target_pipe #(.BASE_ADDR(BASE_ADDR)) u_pipe (
        .clock   (clock),
        .reset   (reset),
        .request (cpu_aux_request),
        .req     (req),
        .abort   (cpu_aux_abort),
        .wr_en   (wr_en),
        .s1_idx  (s1_idx),
        .wr_strb (wr_strb),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .rvalid  (timer_aux_rvalid),
        .rdata   (timer_aux_rdata),
        .rtag    (timer_aux_rtag)
    );

    // Read mux samples current register state, so a read in S1 never sees a
    // write committing at the same edge.
    always_comb begin
        case (s1_idx)
            REG_CTRL:    rd_data = {29'd0, ctrl_q};
            REG_RELOAD:  rd_data = reload_q;
            REG_COUNT:   rd_data = count_q;
            REG_STATUS:  rd_data = {31'd0, expired_q};
            REG_SCRATCH: rd_data = scratch_q;
            default:     rd_data = '0;
        endcase
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        reload_d  = reload_q;
        count_d   = count_q;
        expired_d = expired_q;
        scratch_d = scratch_q;
        presc_d   = '0;
        tick      = 1'b0;
        expire    = 1'b0;

        if (ctrl_q[CTRL_EN]) begin
            if (presc_q == PRESC_LAST) tick = 1'b1;
            else                       presc_d = presc_q + 16'd1;
        end

        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                expire = 1'b1;
                if (ctrl_q[CTRL_AUTORELOAD]) count_d = reload_q;
                else                         ctrl_d[CTRL_EN] = 1'b0;
            end
        end

        // Software writes override the timer's own updates; a CTRL write
        // without byte 0 leaves the hardware EN clear in place.
        if (wr_en) begin
            case (s1_idx)
                REG_CTRL:    if (wr_strb[0]) ctrl_d = wr_data[2:0];
                REG_RELOAD:  reload_d  = apply_wstrb(reload_q, wr_data, wr_strb);
                REG_COUNT:   count_d   = apply_wstrb(count_q, wr_data, wr_strb);
                REG_STATUS:  if (wr_strb[0] && wr_data[0]) expired_d = 1'b0;
                REG_SCRATCH: scratch_d = apply_wstrb(scratch_q, wr_data, wr_strb);
                default:     ;
            endcase
        end

        // Hardware set wins over a same-cycle clear.
        if (expire) expired_d = 1'b1;

        irq_d = expired_q && ctrl_q[CTRL_IRQEN];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_q    <= '0;
            reload_q  <= '0;
            count_q   <= '0;
            expired_q <= 1'b0;
            scratch_q <= '0;
            presc_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            reload_q  <= reload_d;
            count_q   <= count_d;
            expired_q <= expired_d;
            scratch_q <= scratch_d;
            presc_q   <= presc_d;
            irq_q     <= irq_d;
        end
    end

    assign timer_irq = irq_q;

endmodule
